// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
//   owner_t       : which requester owns the read that is returning this cycle
//   IMEM_ADDR_W   : default ROM word-address width
//   IMEM_DATA_W   : default ROM word width
//   STARVE_W      : width of the IF starvation counter (holds 0..15)
package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned IMEM_ADDR_W = 30;
  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned STARVE_W    = 4;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the load unit, the arbiter and the ROM.
// Handshake: a requester raises *_req with a stable *_addr and keeps both
// stable until *_gnt is seen high in the same cycle; the grant completes the
// request at that clock edge. Dropping *_req before a grant is legal. The
// return path has no backpressure: *_rvalid is high for exactly one cycle,
// one cycle after the granting edge, and *_rdata must be taken then.
// Modports:
//   slave  : the arbiter (consumes requests and ROM data, drives grants,
//            returns and the ROM address)
//   master : the requester/ROM side (the opposite directions)
interface imem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_addr
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_addr
  );

endinterface

// File: rtl/imem_arb_pick.sv
// Combinational winner select for the shared ROM read port.
// Default build: D wins contention unless the starvation counter has reached
// MAX_STARVE, in which case IF wins.
// With IMEM_ARB_RR_EN defined: contention is resolved by the round-robin
// pointer (0 = IF, 1 = D) and the starvation counter input is absent.
// Ports:
//   if_req_i, d_req_i : request lines
//   starve_cnt_i      : consecutive IF denials (default build only)
//   rr_ptr_i          : round-robin pointer (IMEM_ARB_RR_EN build only)
//   if_gnt_o, d_gnt_o : one-hot (or zero) grants
module imem_arb_pick
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
`ifdef IMEM_ARB_RR_EN
  input  logic                rr_ptr_i,
`else
  input  logic [STARVE_W-1:0] starve_cnt_i,
`endif
  output logic                if_gnt_o,
  output logic                d_gnt_o
);

  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (if_req_i && d_req_i) begin
`ifdef IMEM_ARB_RR_EN
      if (rr_ptr_i == 1'b0) if_gnt_o = 1'b1;
      else                  d_gnt_o  = 1'b1;
`else
      if (starve_cnt_i == STARVE_W'(MAX_STARVE)) if_gnt_o = 1'b1;
      else                                       d_gnt_o  = 1'b1;
`endif
    end else begin
      if_gnt_o = if_req_i;
      d_gnt_o  = d_req_i;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single read port of the program ROM between instruction fetch
// (IF) and data loads (D). The ROM registers mem_addr every clock and returns
// data one cycle later; the owner register steers that data to the requester
// that was granted at the previous edge. Fully pipelined: one grant per cycle.
// Optional feature macro: IMEM_ARB_RR_EN (round-robin contention instead of
// D-priority with IF starvation guard). Port list and latency are the same
// in both builds.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : imem_port_arbiter_if.slave (requests, grants, returns, ROM)
//   dbg_owner_o  : current owner register, for observation only
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DATA_W     = IMEM_DATA_W,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  imem_port_arbiter_if.slave        bus,
  output owner_t                    dbg_owner_o
);

  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] mem_addr;
  logic              if_gnt, d_gnt;

`ifdef IMEM_ARB_RR_EN
  logic              rr_ptr_q, rr_ptr_d;
`else
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

  imem_arb_pick #(
    .MAX_STARVE (MAX_STARVE)
  ) u_pick (
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
`ifdef IMEM_ARB_RR_EN
    .rr_ptr_i     (rr_ptr_q),
`else
    .starve_cnt_i (starve_cnt_q),
`endif
    .if_gnt_o     (if_gnt),
    .d_gnt_o      (d_gnt)
  );

  // State register: owner, held ROM address and the fairness state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      last_addr_q  <= '0;
`ifdef IMEM_ARB_RR_EN
      rr_ptr_q     <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      owner_q      <= owner_d;
      last_addr_q  <= last_addr_d;
`ifdef IMEM_ARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Next-state logic. With no grant the ROM keeps seeing the last granted
  // address so its address pins do not toggle while idle.
  always_comb begin
    owner_d  = OWN_NONE;
    mem_addr = last_addr_q;
    if (if_gnt) begin
      owner_d  = OWN_IF;
      mem_addr = bus.if_addr;
    end else if (d_gnt) begin
      owner_d  = OWN_D;
      mem_addr = bus.d_addr;
    end
    last_addr_d = mem_addr;
`ifdef IMEM_ARB_RR_EN
    // Only a contended grant moves the pointer, and it moves away from the winner.
    rr_ptr_d = rr_ptr_q;
    if (bus.if_req && bus.d_req) rr_ptr_d = if_gnt ? 1'b1 : 1'b0;
`else
    // Saturating count of consecutive cycles IF asked and lost.
    if (bus.if_req && !if_gnt)
      starve_cnt_d = (starve_cnt_q == STARVE_W'(MAX_STARVE)) ? starve_cnt_q
                                                              : starve_cnt_q + 1'b1;
    else
      starve_cnt_d = '0;
`endif
  end

  // Outputs: grants and ROM address are combinational, returns come from owner_q.
  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_addr  = mem_addr;
    bus.if_rvalid = (owner_q == OWN_IF);
    bus.d_rvalid  = (owner_q == OWN_D);
    bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.d_rdata   = (owner_q == OWN_D)  ? bus.mem_rdata : {DATA_W{1'b0}};
    dbg_owner_o   = owner_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: table of per-cycle request vectors with
// expected grants and ROM address, a ROM model, and a scoreboard queue that
// holds the expected return for each cycle. Build with IMEM_ARB_RR_EN defined
// to exercise the round-robin contention rows instead of the priority rows.
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  owner_t dbg_owner;

  imem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MAX_STARVE (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_owner_o (dbg_owner)
  );

  // ROM contents: a distinct word per address.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction

  // ROM model: samples mem_addr each rising edge, data available next cycle.
  always @(posedge clk) bus.mem_rdata <= rom_f(bus.mem_addr);

  // ---------------- scoreboard ----------------
  // Each entry: {owner code, expected data}; one entry per applied cycle.
  logic [DW+1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the registered return path against the oldest expected entry.
  task automatic check_return(input string tag);
    logic [DW+1:0] e;
    logic [1:0]    own;
    logic [DW-1:0] dat;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    own = e[DW+1:DW];
    dat = e[DW-1:0];
    chk({tag, " if_rvalid"}, 64'(bus.if_rvalid), 64'(own == 2'd1));
    chk({tag, " d_rvalid"},  64'(bus.d_rvalid),  64'(own == 2'd2));
    chk({tag, " if_rdata"},  64'(bus.if_rdata),  64'((own == 2'd1) ? dat : '0));
    chk({tag, " d_rdata"},   64'(bus.d_rdata),   64'((own == 2'd2) ? dat : '0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          exp_if_gnt;
    logic          exp_d_gnt;
    logic [AW-1:0] exp_mem_addr;
  } row_t;

  row_t rows[$];

  task automatic add(input logic ir, input logic [AW-1:0] ia, input logic dr,
                     input logic [AW-1:0] da, input logic eig, input logic edg,
                     input logic [AW-1:0] em);
    row_t r;
    r.if_req = ir; r.if_addr = ia; r.d_req = dr; r.d_addr = da;
    r.exp_if_gnt = eig; r.exp_d_gnt = edg; r.exp_mem_addr = em;
    rows.push_back(r);
  endtask

  // ---------------- driver ----------------
  // One cycle: check last cycle's return, drive, check grants/address, queue expectation.
  task automatic apply(input row_t r, input string tag);
    @(negedge clk);
    check_return(tag);
    bus.if_req  = r.if_req;
    bus.if_addr = r.if_addr;
    bus.d_req   = r.d_req;
    bus.d_addr  = r.d_addr;
    #1;
    chk({tag, " if_gnt"},   64'(bus.if_gnt),   64'(r.exp_if_gnt));
    chk({tag, " d_gnt"},    64'(bus.d_gnt),    64'(r.exp_d_gnt));
    chk({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(r.exp_mem_addr));
    if (r.exp_if_gnt)     exp_q.push_back({2'd1, rom_f(r.exp_mem_addr)});
    else if (r.exp_d_gnt) exp_q.push_back({2'd2, rom_f(r.exp_mem_addr)});
    else                  exp_q.push_back({2'd0, {DW{1'b0}}});
  endtask

  row_t hr;

  initial begin
    // Contention rows after reset.
`ifdef IMEM_ARB_RR_EN
    add(1, 'h10, 1, 'h20, 1, 0, 'h10);
    add(1, 'h11, 1, 'h20, 0, 1, 'h20);
    add(1, 'h11, 1, 'h21, 1, 0, 'h11);
    add(1, 'h12, 1, 'h21, 0, 1, 'h21);
    add(1, 'h12, 1, 'h22, 1, 0, 'h12);
`else
    add(1, 'h10, 1, 'h20, 0, 1, 'h20);
    add(1, 'h10, 1, 'h21, 0, 1, 'h21);
    add(1, 'h10, 1, 'h22, 0, 1, 'h22);
    add(1, 'h10, 1, 'h23, 0, 1, 'h23);
    add(1, 'h10, 1, 'h24, 1, 0, 'h10);
    add(1, 'h11, 1, 'h24, 0, 1, 'h24);
    add(1, 'h11, 1, 'h25, 0, 1, 'h25);
    add(1, 'h11, 1, 'h26, 0, 1, 'h26);
    add(1, 'h11, 1, 'h27, 0, 1, 'h27);
    add(1, 'h11, 1, 'h28, 1, 0, 'h11);
`endif
    // IF only, back-to-back.
    for (int a = 0; a < 4; a++) add(1, AW'(a), 0, 'h3FF, 1, 0, AW'(a));
    // Idle holds the last address; a new load moves it the same cycle.
    add(0, 'h7, 1, 'h19, 0, 1, 'h19);
    add(0, 'h7, 0, 'h5,  0, 0, 'h19);
    add(0, 'h7, 0, 'h5,  0, 0, 'h19);
    add(0, 'h7, 1, 'h8,  0, 1, 'h8);
    add(0, 'h7, 0, 'h9,  0, 0, 'h8);
`ifndef IMEM_ARB_RR_EN
    // Starvation count restarts when IF stops asking.
    add(1, 'h30, 1, 'h31, 0, 1, 'h31);
    add(0, 'h30, 1, 'h32, 0, 1, 'h32);
    add(1, 'h30, 1, 'h33, 0, 1, 'h33);
    add(1, 'h30, 1, 'h34, 0, 1, 'h34);
    add(1, 'h30, 1, 'h35, 0, 1, 'h35);
    add(1, 'h30, 1, 'h36, 0, 1, 'h36);
    add(1, 'h30, 1, 'h37, 1, 0, 'h30);
    // IF request withdrawn before grant: only the D read returns.
    add(1, 'h40, 1, 'h38, 0, 1, 'h38);
    add(0, 'h40, 1, 'h39, 0, 1, 'h39);
`endif
    add(0, 'h0, 0, 'h0, 0, 0, 'h39 - (`ifdef IMEM_ARB_RR_EN 'h39 - 'h8 `else 'h0 `endif));

    // Reset held with both requests high: nothing returns.
    rst_n       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 'h10;
    bus.d_req   = 1'b1;
    bus.d_addr  = 'h20;
    repeat (2) begin
      @(negedge clk);
      chk("reset if_rvalid", 64'(bus.if_rvalid), 64'(0));
      chk("reset d_rvalid",  64'(bus.d_rvalid),  64'(0));
      chk("reset owner",     64'(dbg_owner),     64'(OWN_NONE));
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) apply(rows[i], $sformatf("row%0d", i));

    // Reset pulsed the cycle after a D grant discards that read.
    hr.if_req = 0; hr.if_addr = 'h0; hr.d_req = 1; hr.d_addr = 'h2A;
    hr.exp_if_gnt = 0; hr.exp_d_gnt = 1; hr.exp_mem_addr = 'h2A;
    apply(hr, "pre_rst");
    @(negedge clk);
    check_return("pre_rst_ret");
    rst_n      = 1'b0;
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    #1;
    chk("mid_rst d_rvalid", 64'(bus.d_rvalid), 64'(0));
    chk("mid_rst owner",    64'(dbg_owner),    64'(OWN_NONE));
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("post_rst owner", 64'(dbg_owner), 64'(OWN_NONE));
    hr.d_req = 0; hr.exp_d_gnt = 0; hr.exp_mem_addr = 'h0;
    for (int i = 0; i < 3; i++) apply(hr, $sformatf("post_rst%0d", i));
    @(negedge clk);
    check_return("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
